ofm_buffer: RTL and testbench

Parametrised output-feature-map buffer for the CNN datapath. It stores DEPTH = ROWS*COLS signed words of DATA_W bits, indexed linearly: row = addr / COLS, column = addr % COLS. Beyond plain writes it adds:
- a registered read port;
- a saturating accumulate mode for summing partial results across input channels;
- a multi-cycle clear sweep that runs after reset and on request.

It sits between the PE array output and the result readout logic.

---
 rtl/ofm_buffer.sv | 173 +++++++++++++++++
 tb/tb_ofm_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ofm_buffer.sv
// ofm_buffer -- output-feature-map buffer for the CNN datapath.
//
// Holds DEPTH = ROWS*COLS signed DATA_W-bit words, addressed linearly
// (row = addr / COLS, column = addr % COLS). It accepts one write per cycle,
// either as an overwrite or as a saturating accumulate. It also provides a
// registered read port and a multi-cycle clear sweep that runs after reset
// and on request.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset; restarts the clear sweep
//   clr       one-cycle request to start a clear sweep (IDLE only)
//   busy      high while the clear sweep runs (the FSM state, registered)
//   wren      write request
//   acc_mode  with wren: 1 = saturating accumulate, 0 = overwrite
//   wr_addr   write address
//   wr_data   write data / addend
//   rden      read request
//   rd_addr   read address
//   rd_data   registered read data
//   rd_valid  high one cycle after an accepted read
//   ovf       sticky saturation flag, cleared by rst or clr
//
// Handshake: requests have no back-pressure. In IDLE every wren/rden is
// accepted in the cycle it is high. While busy, all requests are ignored.
// rd_valid is a one-cycle qualifier for rd_data and is never held.
module ofm_buffer #(
   parameter int DATA_W = 8,
   parameter int ROWS   = 32,
   parameter int COLS   = 4,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   output logic              busy,
   input  logic              wren,
   input  logic              acc_mode,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rden,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              ovf
);

   localparam int DEPTH = ROWS * COLS;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic              wp_valid_q, wp_valid_d;
   logic [IDX_W-1:0]  wp_addr_q, wp_addr_d;
   logic [DATA_W-1:0] wp_data_q, wp_data_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              ovf_q, ovf_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_in_range, rd_in_range;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [DATA_W-1:0] wr_old, rd_new, sat_val;
   logic [DATA_W:0]   sum;
   logic              sat_hit;
   logic              sweep_wr;
   logic              commit_en;

   assign wr_in_range = int'(wr_addr) < DEPTH;
   assign rd_in_range = int'(rd_addr) < DEPTH;
   assign wr_idx      = wr_addr[IDX_W-1:0];
   assign rd_idx      = rd_addr[IDX_W-1:0];

   // The in-flight write is the newest copy of its word.
   // Both the accumulate operand and the read data are taken from it on an address match.
   always_comb begin
      wr_old  = (wp_valid_q && wp_addr_q == wr_idx) ? wp_data_q : mem[wr_idx];
      rd_new  = (wp_valid_q && wp_addr_q == rd_idx) ? wp_data_q : mem[rd_idx];
      sum     = {wr_old[DATA_W-1], wr_old} + {wr_data[DATA_W-1], wr_data};
      // The top two bits of the widened sum differ exactly when the
      // DATA_W-bit result would have wrapped.
      sat_hit = sum[DATA_W] ^ sum[DATA_W-1];
      sat_val = sat_hit ? (sum[DATA_W] ? MIN_V : MAX_V) : sum[DATA_W-1:0];
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      wp_valid_d = 1'b0;
      wp_addr_d  = wp_addr_q;
      wp_data_d  = wp_data_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      ovf_d      = ovf_q;
      sweep_wr   = 1'b0;
      commit_en  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            sweep_wr = 1'b1;
            ptr_d    = ptr_q + IDX_W'(1);
            if (ptr_q == IDX_W'(DEPTH - 1)) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end
         end
         ST_IDLE: begin
            // An accepted clr squashes the write that would commit this cycle.
            commit_en = wp_valid_q && !clr;
            if (rden) begin
               rd_valid_d = 1'b1;
               rd_data_d  = rd_in_range ? rd_new : '0;
            end
            if (clr) begin
               state_d = ST_CLEAR;
               ptr_d   = '0;
               ovf_d   = 1'b0;
            end else if (wren && wr_in_range) begin
               wp_valid_d = 1'b1;
               wp_addr_d  = wr_idx;
               wp_data_d  = acc_mode ? sat_val : wr_data;
               if (acc_mode && sat_hit) begin
                  ovf_d = 1'b1;
               end
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         ptr_q      <= '0;
         wp_valid_q <= 1'b0;
         wp_addr_q  <= '0;
         wp_data_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         wp_valid_q <= wp_valid_d;
         wp_addr_q  <= wp_addr_d;
         wp_data_q  <= wp_data_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage has no reset. rst only suppresses the commit of a pending write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (sweep_wr) begin
            mem[ptr_q] <= '0;
         end else if (commit_en) begin
            mem[wp_addr_q] <= wp_data_q;
         end
      end
   end

   assign busy     = (state_q == ST_CLEAR);
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_ofm_buffer.sv
// Self-checking bench for ofm_buffer (ROWS=32, COLS=4, ADDR_W=8 so that
// out-of-range addresses can be driven).
module tb_ofm_buffer;

  localparam int DEPTH = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       busy;
  logic       wren = 1'b0;
  logic       acc_mode = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rden = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ovf;

  ofm_buffer #(.DATA_W(8), .ROWS(32), .COLS(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy),
    .wren(wren), .acc_mode(acc_mode), .wr_addr(wr_addr), .wr_data(wr_data),
    .rden(rden), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .ovf(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: the buffer as an ideal array with writes applied at
  // request time; reads see everything requested in earlier cycles
  logic [7:0] m_mem [DEPTH];
  logic       m_ovf;
  int         busy_cnt;
  logic [7:0] exp_rd;
  logic       exp_valid;
  int         quiet;
  int         errors = 0;
  int         checks = 0;

  // scoreboard of expected reads from the table
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; wren = 1'b0; rden = 1'b0; acc_mode = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    busy_cnt = DEPTH;
    exp_rd   = 8'h00;
    m_ovf    = 1'b0;
    quiet    = 2;
    model_zero();
    chk("rst_busy", busy, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ovf", ovf, 0);
  endtask

  // one clock cycle: check state-level outputs, drive, update model, check read port
  task automatic step(input logic we, input logic am, input logic [7:0] wa,
                      input logic [7:0] wd, input logic re, input logic [7:0] ra,
                      input logic cl);
    logic busy_now;
    int   s;
    busy_now = (busy_cnt > 0);
    chk("busy", busy, busy_now);
    if (quiet >= 2) chk("ovf", ovf, m_ovf);
    wren = we; acc_mode = am; wr_addr = wa; wr_data = wd;
    rden = re; rd_addr = ra; clr = cl;
    exp_valid = 1'b0;
    if (busy_now) begin
      busy_cnt--;
    end else begin
      if (re) begin
        exp_valid = 1'b1;
        exp_rd = (int'(ra) < DEPTH) ? m_mem[int'(ra)] : 8'h00;
      end
      if (cl) begin
        busy_cnt = DEPTH;
        m_ovf = 1'b0;
        model_zero();
      end else if (we && int'(wa) < DEPTH) begin
        if (am) begin
          s = int'($signed(m_mem[int'(wa)])) + int'($signed(wd));
          if (s > 127) begin s = 127; m_ovf = 1'b1; end
          if (s < -128) begin s = -128; m_ovf = 1'b1; end
          m_mem[int'(wa)] = 8'(s);
        end else begin
          m_mem[int'(wa)] = wd;
        end
      end
    end
    quiet = ((we || cl) && !busy_now) ? 0 : quiet + 1;
    @(posedge clk); #1;
    wren = 1'b0; rden = 1'b0; clr = 1'b0;
    chk("rd_valid", rd_valid, exp_valid);
    chk("rd_data", rd_data, exp_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
  endtask

  typedef struct {
    logic       we;
    logic       am;
    logic [7:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [7:0] ra;
    logic       cl;
    logic [7:0] exp_rd;
    logic       exp_v;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // directed vectors on a freshly cleared buffer
    vecs[0]  = '{1'b1, 1'b0, 8'd9,   8'h35, 1'b1, 8'd9,   1'b0, 8'h00, 1'b1}; // same-cycle read: old value
    vecs[1]  = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b1, 8'd9,   1'b0, 8'h35, 1'b1}; // read-after-write
    vecs[2]  = '{1'b1, 1'b1, 8'd5,   8'h03, 1'b0, 8'd0,   1'b0, 8'h35, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'd5,   8'h04, 1'b0, 8'd0,   1'b0, 8'h35, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'd5,   8'hFE, 1'b0, 8'd0,   1'b0, 8'h35, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b1, 8'd5,   1'b0, 8'h05, 1'b1}; // 3+4-2
    vecs[6]  = '{1'b1, 1'b0, 8'd2,   8'd100, 1'b0, 8'd0,  1'b0, 8'h05, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 8'd2,   8'd50, 1'b0, 8'd0,   1'b0, 8'h05, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b1, 8'd2,   1'b0, 8'h7F, 1'b1}; // clamp high
    vecs[9]  = '{1'b1, 1'b0, 8'd3,   8'hFF, 1'b0, 8'd0,   1'b0, 8'h7F, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'd3,   8'h80, 1'b1, 8'd3,   1'b0, 8'hFF, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b1, 8'd3,   1'b0, 8'h80, 1'b1}; // clamp low
    vecs[12] = '{1'b1, 1'b0, 8'd200, 8'h11, 1'b0, 8'd0,   1'b0, 8'h80, 1'b0}; // dropped
    vecs[13] = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b1, 8'd200, 1'b0, 8'h00, 1'b1}; // out of range read
    vecs[14] = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b1, 8'd72,  1'b0, 8'h00, 1'b1}; // no aliasing of 200
    vecs[15] = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 8'd0,   1'b0, 8'h00, 1'b0}; // hold

    do_reset();
    idle(DEPTH);
    // every word reads back zero after the sweep
    for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 8'h00, 1, 8'(i), 0);

    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(vecs[i].exp_rd);
      step(vecs[i].we, vecs[i].am, vecs[i].wa, vecs[i].wd,
           vecs[i].re, vecs[i].ra, vecs[i].cl);
      chk("vec_rd_valid", rd_valid, vecs[i].exp_v);
      chk("vec_rd_data", rd_data, exp_q.pop_front());
    end
    idle(2);
    chk("ovf_sticky", ovf, 1);

    // clr beats a same-cycle write; ovf clears; sweep lasts DEPTH cycles
    step(1, 0, 8'd1, 8'h55, 0, 8'h00, 1);
    chk("clr_ovf", ovf, 0);
    idle(DEPTH);
    step(0, 0, 8'h00, 8'h00, 1, 8'd1, 0);
    chk("clr_wins_rd", rd_data, 0);
    step(0, 0, 8'h00, 8'h00, 1, 8'd2, 0);
    chk("clr_swept_rd", rd_data, 0);

    // reset in the middle of a sweep restarts it, reads stay blocked
    step(0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
    idle(60);
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 8'h00, 1, 8'(i), 0);
    chk("post_sweep_busy", busy, 0);

    // a write in flight at reset is squashed
    step(1, 0, 8'd7, 8'h42, 0, 8'h00, 0);
    do_reset();
    idle(DEPTH);
    step(0, 0, 8'h00, 8'h00, 1, 8'd7, 0);

    // randomized traffic with a small hot address set to stress forwarding
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 135)) : 8'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 135)) : 8'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), wa, 8'($urandom),
           1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 299) == 0));
    end
    idle(DEPTH + 2);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 8'h00, 1, 8'(i), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
